// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared mode/direction encodings for the multi-mode timer
package timer_pkg;

  localparam logic [1:0] MODE_ENC_UP     = 2'b00;
  localparam logic [1:0] MODE_ENC_DOWN   = 2'b01;
  localparam logic [1:0] MODE_ENC_CENTER = 2'b10;
  localparam logic [1:0] MODE_ENC_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    MODE_UP     = MODE_ENC_UP,
    MODE_DOWN   = MODE_ENC_DOWN,
    MODE_CENTER = MODE_ENC_CENTER,
    MODE_RSVD   = MODE_ENC_RSVD
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // The reserved encoding behaves as UP, so it is folded away before reaching the active register
  function automatic mode_e decode_mode(input logic [1:0] m);
    return (m == MODE_ENC_RSVD) ? MODE_UP : mode_e'(m);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - clock prescaler producing a one-clock step strobe every psc+1 running clocks
module timer_prescaler #(
  parameter int PSC_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [PSC_W-1:0] psc,
  output logic             step
);

  logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;

  // >= rather than == so a divider lowered while paused cannot leave the count stranded above it
  always_comb begin
    psc_cnt_d = psc_cnt_q;
    step      = run && (psc_cnt_q >= psc);
    if (run) begin
      psc_cnt_d = step ? '0 : psc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule

// File: rtl/multi_mode_timer.sv
// rtl/multi_mode_timer.sv - prescaled auto-reload timer with up/down/centre modes, one-shot and PWM compares
module multi_mode_timer
  import timer_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int PSC_W  = 5,
  parameter int NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [PSC_W-1:0]        psc,
  input  logic [CNT_W-1:0]        reload,
  input  logic [1:0]              mode,
  input  logic                    one_shot,
  input  logic [NUM_CH*CNT_W-1:0] cmp,
  output logic [CNT_W-1:0]        counter,
  output logic                    tick,
  output logic                    dir,
  output logic                    running,
  output logic [NUM_CH-1:0]       pwm
);

  logic [PSC_W-1:0]        psc_q, psc_d;
  logic [CNT_W-1:0]        reload_q, reload_d;
  mode_e                   mode_q, mode_d, mode_in;
  logic [NUM_CH*CNT_W-1:0] cmp_q, cmp_d;
  logic [CNT_W-1:0]        counter_q, counter_d;
  dir_e                    dir_q, dir_d;
  logic                    tick_q, tick_d;
  logic                    halted_q, halted_d;
  logic                    step, wrap, load;

  assign running = en && !halted_q;
  assign mode_in = decode_mode(mode);

  timer_prescaler #(.PSC_W(PSC_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (running),
    .psc   (psc_q),
    .step  (step)
  );

  always_comb begin
    counter_d = counter_q;
    dir_d     = dir_q;
    wrap      = 1'b0;
    if (step) begin
      case (mode_q)
        MODE_DOWN: begin
          if (counter_q == '0) begin
            counter_d = reload_q;
            wrap      = 1'b1;
          end else begin
            counter_d = counter_q - 1'b1;
          end
        end
        MODE_CENTER: begin
          if (reload_q == '0) begin
            counter_d = '0;
            dir_d     = DIR_UP;
            wrap      = 1'b1;
          end else if (dir_q == DIR_UP) begin
            if (counter_q >= reload_q) begin
              dir_d     = DIR_DOWN;
              counter_d = counter_q - 1'b1;
            end else begin
              counter_d = counter_q + 1'b1;
            end
          end else if (counter_q == '0) begin
            dir_d     = DIR_UP;
            counter_d = counter_q + 1'b1;
            wrap      = 1'b1;
          end else begin
            counter_d = counter_q - 1'b1;
          end
        end
        default: begin
          if (counter_q >= reload_q) begin
            counter_d = '0;
            wrap      = 1'b1;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
      endcase
    end

    // Shadow registers track the inputs while stopped and otherwise swap in at the period boundary
    load     = !en || wrap;
    psc_d    = load ? psc    : psc_q;
    reload_d = load ? reload : reload_q;
    mode_d   = load ? mode_in : mode_q;
    cmp_d    = load ? cmp    : cmp_q;
    if (load && (mode_in != mode_q)) begin
      dir_d = (mode_in == MODE_DOWN) ? DIR_DOWN : DIR_UP;
    end

    tick_d   = wrap;
    halted_d = halted_q;
    if (!en) begin
      halted_d = 1'b0;
    end else if (wrap && one_shot) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      psc_q     <= '0;
      reload_q  <= '0;
      mode_q    <= MODE_UP;
      cmp_q     <= '0;
      counter_q <= '0;
      dir_q     <= DIR_UP;
      tick_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      psc_q     <= psc_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      cmp_q     <= cmp_d;
      counter_q <= counter_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      halted_q  <= halted_d;
    end
  end

  assign counter = counter_q;
  assign tick    = tick_q;
  assign dir     = dir_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_pwm
    assign pwm[i] = (counter_q < cmp_q[i*CNT_W +: CNT_W]);
  end

endmodule
